// File: rtl/toplevel_pll_ctrl_if.sv
// Bundle between the PLL sequencer and its surroundings. The design is the slave
// side: it takes the PLL LOCK and drives the PLL reset plus the status outputs.
interface toplevel_pll_ctrl_if #(
   parameter int MAX_RETRIES = 3
);
   localparam int RC_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

   logic            LOCK;
   logic            PLLRESETB;
   logic            SYSRESET;
   logic            READY;
   logic            ERROR;
   logic [RC_W-1:0] RETRY_COUNT;
   logic [2:0]      STATE;

   modport slave (
      input  LOCK,
      output PLLRESETB, SYSRESET, READY, ERROR, RETRY_COUNT, STATE
   );

   modport master (
      output LOCK,
      input  PLLRESETB, SYSRESET, READY, ERROR, RETRY_COUNT, STATE
   );
endinterface

// File: rtl/toplevel_pll_ctrl.sv
// PLL reset sequencer on the board reference clock: holds RESETB, waits for a
// qualified LOCK with timeout and bounded retries, then releases the SoC reset.
module toplevel_pll_ctrl #(
   parameter int RESET_HOLD_CYCLES   = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 100000,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int MAX_RETRIES         = 3
) (
   input  logic               REFERENCECLK,
   input  logic               RESET,
   toplevel_pll_ctrl_if.slave pll_if
);
   localparam int MAX_AB  = (RESET_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                            RESET_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
   localparam int MAX_CYC = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam int RC_W    = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [RC_W-1:0]  RETRY_MAX   = RC_W'(MAX_RETRIES);

   typedef enum logic [2:0] {
      ST_HOLD      = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAIL      = 3'd4
   } state_t;

   logic             sync1_q, lock_s_q;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [RC_W-1:0]  retry_q, retry_d;
   logic             pllresetb_q, sysreset_q, ready_q, error_q;

   // LOCK is asynchronous to REFERENCECLK; only the second flop is ever used
   always_ff @(posedge REFERENCECLK or negedge RESET) begin
      if (!RESET) begin
         sync1_q  <= 1'b0;
         lock_s_q <= 1'b0;
      end else begin
         sync1_q  <= pll_if.LOCK;
         lock_s_q <= sync1_q;
      end
   end

   // Next-state, retry and shared cycle counter
   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      case (state_q)
         ST_HOLD: begin
            if (cnt_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
            else                    state_d = ST_HOLD;
         end
         ST_WAIT_LOCK: begin
            // lock wins over a coincident timeout
            if (lock_s_q) begin
               state_d = ST_STABLE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               if (retry_q == RETRY_MAX) begin
                  state_d = ST_FAIL;
               end else begin
                  retry_d = retry_q + RC_W'(1);
                  state_d = ST_HOLD;
               end
            end else begin
               state_d = ST_WAIT_LOCK;
            end
         end
         ST_STABLE: begin
            if (!lock_s_q) begin
               state_d = ST_WAIT_LOCK;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = ST_RUN;
               retry_d = '0;
            end else begin
               state_d = ST_STABLE;
            end
         end
         ST_RUN: begin
            if (!lock_s_q) state_d = ST_HOLD;
            else           state_d = ST_RUN;
         end
         ST_FAIL: state_d = ST_FAIL;
         default: state_d = ST_HOLD;
      endcase

      // RUN and FAIL have no terminal count, so the counter just parks there
      if (state_d != state_q)                         cnt_d = '0;
      else if (state_q == ST_RUN || state_q == ST_FAIL) cnt_d = cnt_q;
      else                                            cnt_d = cnt_q + CNT_W'(1);
   end

   // State, counter and outputs; outputs decode next-state to switch with the state
   always_ff @(posedge REFERENCECLK or negedge RESET) begin
      if (!RESET) begin
         state_q     <= ST_HOLD;
         cnt_q       <= '0;
         retry_q     <= '0;
         pllresetb_q <= 1'b0;
         sysreset_q  <= 1'b1;
         ready_q     <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         pllresetb_q <= (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE) ||
                        (state_d == ST_RUN);
         sysreset_q  <= (state_d != ST_RUN);
         ready_q     <= (state_d == ST_RUN);
         error_q     <= (state_d == ST_FAIL);
      end
   end

   assign pll_if.PLLRESETB   = pllresetb_q;
   assign pll_if.SYSRESET    = sysreset_q;
   assign pll_if.READY       = ready_q;
   assign pll_if.ERROR       = error_q;
   assign pll_if.RETRY_COUNT = retry_q;
   assign pll_if.STATE       = state_q;
endmodule

// File: tb/tb_toplevel_pll_ctrl.sv
// Directed bench for toplevel_pll_ctrl with short hold/timeout/stable periods.
module tb_toplevel_pll_ctrl;
   localparam int HOLD = 4;
   localparam int TO   = 64;
   localparam int STB  = 8;
   localparam int MR   = 2;

   localparam int S_PRB = 0;
   localparam int S_SYS = 1;
   localparam int S_RDY = 2;
   localparam int S_ERR = 3;
   localparam int S_ST  = 4;
   localparam int S_RC  = 5;

   logic refclk  = 1'b0;
   logic reset_n = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   int   n;

   toplevel_pll_ctrl_if #(.MAX_RETRIES(MR)) bus ();

   toplevel_pll_ctrl #(
      .RESET_HOLD_CYCLES  (HOLD),
      .LOCK_TIMEOUT_CYCLES(TO),
      .LOCK_STABLE_CYCLES (STB),
      .MAX_RETRIES        (MR)
   ) dut (
      .REFERENCECLK(refclk),
      .RESET       (reset_n),
      .pll_if      (bus)
   );

   always #5 refclk = ~refclk;

   function automatic logic [31:0] obs(input int sel);
      case (sel)
         S_PRB:   return {31'd0, bus.PLLRESETB};
         S_SYS:   return {31'd0, bus.SYSRESET};
         S_RDY:   return {31'd0, bus.READY};
         S_ERR:   return {31'd0, bus.ERROR};
         S_ST:    return {29'd0, bus.STATE};
         S_RC:    return {30'd0, bus.RETRY_COUNT};
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
      end
   endtask

   task automatic tick();
      @(posedge refclk);
      #1;
   endtask

   // ticks until the selected output equals val; n=-1 if the budget expires
   task automatic wait_sig(input int sel, input logic [31:0] val, output int cnt);
      cnt = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         cnt++;
         if (obs(sel) === val) return;
      end
      cnt = -1;
   endtask

   task automatic do_reset();
      bus.LOCK = 1'b0;
      #3 reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   initial begin
      bus.LOCK = 1'b0;
      #1 reset_n = 1'b0;
      #1;
      chk("rst_prb",   obs(S_PRB), 32'd0);
      chk("rst_sys",   obs(S_SYS), 32'd1);
      chk("rst_rdy",   obs(S_RDY), 32'd0);
      chk("rst_err",   obs(S_ERR), 32'd0);
      chk("rst_state", obs(S_ST),  32'd0);
      chk("rst_rc",    obs(S_RC),  32'd0);
      tick();
      tick();
      chk("rst_hold_state", obs(S_ST), 32'd0);
      reset_n = 1'b1;

      // nominal bring-up
      wait_sig(S_PRB, 32'd1, n);
      chk("nom_hold_len", n, HOLD);
      chk("nom_wait_state", obs(S_ST), 32'd1);
      repeat (20) tick();
      bus.LOCK = 1'b1;
      wait_sig(S_ST, 32'd2, n);
      chk("nom_stable_lat", n, 3);
      chk("nom_sys_in_stable", obs(S_SYS), 32'd1);
      wait_sig(S_SYS, 32'd0, n);
      chk("nom_qual_len", n, STB);
      chk("nom_ready", obs(S_RDY), 32'd1);
      chk("nom_rc", obs(S_RC), 32'd0);
      chk("nom_state", obs(S_ST), 32'd3);
      chk("nom_prb", obs(S_PRB), 32'd1);

      // lock loss in RUN
      bus.LOCK = 1'b0;
      wait_sig(S_SYS, 32'd1, n);
      chk("loss_lat", n, 3);
      chk("loss_ready", obs(S_RDY), 32'd0);
      chk("loss_prb", obs(S_PRB), 32'd0);
      chk("loss_state", obs(S_ST), 32'd0);
      bus.LOCK = 1'b1;
      wait_sig(S_PRB, 32'd1, n);
      chk("loss_hold_len", n, HOLD);
      wait_sig(S_SYS, 32'd0, n);
      chk("loss_resequence", n, 1 + STB);
      chk("loss_rc", obs(S_RC), 32'd0);
      chk("loss_ready_again", obs(S_RDY), 32'd1);

      // unstable lock during qualification
      do_reset();
      wait_sig(S_PRB, 32'd1, n);
      chk("unst_hold_len", n, HOLD);
      bus.LOCK = 1'b1;
      repeat (5) tick();
      chk("unst_in_stable", obs(S_ST), 32'd2);
      bus.LOCK = 1'b0;
      tick();
      bus.LOCK = 1'b1;
      wait_sig(S_ST, 32'd1, n);
      chk("unst_abort_lat", n, 2);
      wait_sig(S_ST, 32'd2, n);
      chk("unst_restable_lat", n, 1);
      chk("unst_sys_held", obs(S_SYS), 32'd1);
      wait_sig(S_SYS, 32'd0, n);
      chk("unst_qual_len", n, STB);

      // one timeout then lock on the second attempt
      do_reset();
      wait_sig(S_PRB, 32'd1, n);
      wait_sig(S_PRB, 32'd0, n);
      chk("retry_timeout_len", n, TO);
      chk("retry_rc1", obs(S_RC), 32'd1);
      chk("retry_state_hold", obs(S_ST), 32'd0);
      wait_sig(S_PRB, 32'd1, n);
      chk("retry_hold_len", n, HOLD);
      repeat (2) tick();
      bus.LOCK = 1'b1;
      wait_sig(S_ST, 32'd2, n);
      chk("retry_stable_lat", n, 3);
      chk("retry_rc_kept", obs(S_RC), 32'd1);
      wait_sig(S_SYS, 32'd0, n);
      chk("retry_qual_len", n, STB);
      chk("retry_rc_cleared", obs(S_RC), 32'd0);

      // LOCK never arrives
      do_reset();
      wait_sig(S_PRB, 32'd1, n);
      wait_sig(S_PRB, 32'd0, n);
      chk("fail_win1", n, TO);
      chk("fail_rc1", obs(S_RC), 32'd1);
      wait_sig(S_PRB, 32'd1, n);
      chk("fail_hold2", n, HOLD);
      wait_sig(S_PRB, 32'd0, n);
      chk("fail_win2", n, TO);
      chk("fail_rc2", obs(S_RC), 32'd2);
      wait_sig(S_PRB, 32'd1, n);
      wait_sig(S_ERR, 32'd1, n);
      chk("fail_win3", n, TO);
      chk("fail_prb", obs(S_PRB), 32'd0);
      chk("fail_sys", obs(S_SYS), 32'd1);
      chk("fail_state", obs(S_ST), 32'd4);
      chk("fail_rc_final", obs(S_RC), 32'd2);
      bus.LOCK = 1'b1;
      repeat (20) tick();
      chk("fail_stuck_state", obs(S_ST), 32'd4);
      chk("fail_stuck_err", obs(S_ERR), 32'd1);
      #3 reset_n = 1'b0;
      #1;
      chk("fail_clr_err", obs(S_ERR), 32'd0);
      chk("fail_clr_rc", obs(S_RC), 32'd0);
      chk("fail_clr_state", obs(S_ST), 32'd0);
      bus.LOCK = 1'b0;
      tick();
      reset_n = 1'b1;

      // asynchronous reset while qualifying
      wait_sig(S_PRB, 32'd1, n);
      bus.LOCK = 1'b1;
      wait_sig(S_ST, 32'd2, n);
      chk("areset_stable_lat", n, 3);
      repeat (2) tick();
      #3 reset_n = 1'b0;
      #1;
      chk("areset_prb", obs(S_PRB), 32'd0);
      chk("areset_sys", obs(S_SYS), 32'd1);
      chk("areset_rdy", obs(S_RDY), 32'd0);
      chk("areset_state", obs(S_ST), 32'd0);
      chk("areset_err", obs(S_ERR), 32'd0);
      tick();
      reset_n = 1'b1;
      tick();
      chk("areset_rel_state", obs(S_ST), 32'd0);
      chk("areset_rel_prb", obs(S_PRB), 32'd0);
      wait_sig(S_PRB, 32'd1, n);
      chk("areset_hold_rest", n, HOLD - 1);
      wait_sig(S_SYS, 32'd0, n);
      chk("areset_resequence", n, 1 + STB);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
